// File: rtl/design_select_if.sv
// Pad-side and design-side signal bundle of the multi-project design selector.
// The selector takes the slave view. The harness and the per-design instances
// take the master view.
interface design_select_if #(
  parameter int NUM_DESIGNS = 64,
  parameter int IO_W        = 12
);
  logic [5:0]                  des_sel;
  logic                        sync;
  logic                        hold;
  logic                        user_reset;
  logic [IO_W-1:0]             io_in;
  logic [IO_W-1:0]             io_out;
  logic [IO_W-1:0]             des_io_in;
  logic [NUM_DESIGNS*IO_W-1:0] des_io_out;
  logic [NUM_DESIGNS-1:0]      des_en;
  logic [NUM_DESIGNS-1:0]      des_reset;
  logic [5:0]                  active_des;
  logic                        running;
  logic                        sel_err;

  modport master (
    output des_sel, sync, hold, user_reset, io_in, des_io_out,
    input  io_out, des_io_in, des_en, des_reset, active_des, running, sel_err
  );

  modport slave (
    input  des_sel, sync, hold, user_reset, io_in, des_io_out,
    output io_out, des_io_in, des_en, des_reset, active_des, running, sel_err
  );
endinterface

// File: rtl/design_select.sv
// Chip-side design selector. It synchronizes the harness select pads and
// commits a design number on each sync rising edge. It then holds every design
// in reset for a fixed window before enabling the chosen one. The user IO is
// routed to and from that design only.
module design_select #(
  parameter int NUM_DESIGNS = 64,
  parameter int IO_W        = 12,
  parameter int SYNC_STAGES = 2,
  parameter int RESET_HOLD  = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  design_select_if.slave bus
);

  localparam int              PAD_W    = 9 + IO_W;
  localparam int              CNT_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESET_HOLD - 1);
  localparam logic [6:0]      LIMIT    = 7'(NUM_DESIGNS);

  typedef enum logic [1:0] {IDLE, SWITCH, RUN} state_t;

  logic [SYNC_STAGES-1:0][PAD_W-1:0] pipe;
  logic [5:0]       des_sel_s;
  logic             sync_s, hold_s, user_reset_s, sync_q;
  logic [IO_W-1:0]  io_in_s;
  logic             accept;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [5:0]       active_des, active_des_n;
  logic             sel_err, sel_err_n;

  logic [IO_W-1:0]  slot;
  logic [IO_W-1:0]  io_q;
  logic [IO_W-1:0]  des_io_in_q;

  // The oldest stage of the pipe holds the synchronized (_s) pad values.
  assign {des_sel_s, sync_s, hold_s, user_reset_s, io_in_s} = pipe[SYNC_STAGES-1];
  assign accept = sync_s & ~sync_q & ~hold_s;

  // Pad synchronizers and the sync edge detector. The edge detector keeps
  // tracking under hold, so an edge seen while hold is high is dropped.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe   <= '0;
      sync_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      pipe   <= {pipe[SYNC_STAGES-2:0],
                 {bus.des_sel, bus.sync, bus.hold, bus.user_reset, bus.io_in}};
      sync_q <= sync_s;
    end
  end

  // State register for the selector FSM and its committed selection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      active_des <= '0;
      sel_err    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      active_des <= active_des_n;
      sel_err    <= sel_err_n;
    end
  end

  // Next state. An accepted sync edge overrides whatever state is current.
  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    state_n      = state;
    cnt_n        = cnt;
    active_des_n = active_des;
    sel_err_n    = sel_err;
    if (accept) begin
      active_des_n = des_sel_s;
      if ({1'b0, des_sel_s} < LIMIT) begin
        sel_err_n = 1'b0;
        state_n   = SWITCH;
        cnt_n     = CNT_LOAD;
      end else begin
        sel_err_n = 1'b1;
        state_n   = IDLE;
        cnt_n     = '0;
      end
    end else if (state == SWITCH) begin
      if (cnt == '0) state_n = RUN;
      else           cnt_n   = cnt - 1'b1;
    end
  end

  // Output slice of the committed design.
  always_comb begin
    slot = '0;
    for (int k = 0; k < NUM_DESIGNS; k++) begin
      if (active_des == 6'(k)) slot = bus.des_io_out[k*IO_W +: IO_W];
    end
  end

  // IO registers. Both freeze while hold is high. io_q clears outside RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_q        <= '0;
      des_io_in_q <= '0;
    end else if (!hold_s) begin
      io_q        <= (state == RUN) ? slot : '0;
      des_io_in_q <= io_in_s;
    end
  end

  // Per-design enables and resets. These are decoded from the state so that
  // an asynchronous reset reaches them without a clock edge.
  always_comb begin
    bus.des_en    = '0;
    bus.des_reset = '1;
    bus.io_out    = '0;
    bus.running   = 1'b0;
    if (state == RUN) begin
      bus.running = 1'b1;
      bus.io_out  = io_q;
      for (int k = 0; k < NUM_DESIGNS; k++) begin
        if (active_des == 6'(k)) begin
          bus.des_en[k]    = 1'b1;
          bus.des_reset[k] = user_reset_s;
        end
      end
    end
  end

  assign bus.des_io_in  = des_io_in_q;
  assign bus.active_des = active_des;
  assign bus.sel_err    = sel_err;

endmodule

// File: tb/tb_design_select.sv
// Directed bench for design_select. dut_a uses the default 64 slots. dut_b
// has 8 slots so that an out-of-range design number can be exercised.
module tb_design_select;

  localparam int IO_W = 12;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  design_select_if #(.NUM_DESIGNS(64), .IO_W(IO_W)) bus_a ();
  design_select_if #(.NUM_DESIGNS(8),  .IO_W(IO_W)) bus_b ();

  design_select #(.NUM_DESIGNS(64), .IO_W(IO_W), .SYNC_STAGES(2), .RESET_HOLD(4)) dut_a (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_a.slave)
  );

  design_select #(.NUM_DESIGNS(8), .IO_W(IO_W), .SYNC_STAGES(2), .RESET_HOLD(4)) dut_b (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus_b.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advances to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus_a.des_sel = '0; bus_a.sync = 1'b0; bus_a.hold = 1'b0; bus_a.user_reset = 1'b0;
    bus_a.io_in = '0; bus_a.des_io_out = '0;
    bus_b.des_sel = '0; bus_b.sync = 1'b0; bus_b.hold = 1'b0; bus_b.user_reset = 1'b0;
    bus_b.io_in = '0; bus_b.des_io_out = '0;

    // Reset and idle.
    #12;
    check("rst_running",   64'(bus_a.running),    64'd0);
    check("rst_des_en",    bus_a.des_en,          64'd0);
    check("rst_des_reset", bus_a.des_reset,       ONES);
    check("rst_io_out",    64'(bus_a.io_out),     64'd0);
    check("rst_des_io_in", 64'(bus_a.des_io_in),  64'd0);
    check("rst_active",    64'(bus_a.active_des), 64'd0);
    check("rst_sel_err",   64'(bus_a.sel_err),    64'd0);
    check("rst_b_reset",   64'(bus_b.des_reset),  64'hFF);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_des_reset", bus_a.des_reset,    ONES);
      check("idle_io_out",    64'(bus_a.io_out),  64'd0);
      check("idle_running",   64'(bus_a.running), 64'd0);
    end

    // Illegal design number on the 8-slot instance, then a legal one.
    bus_b.des_sel = 6'd12;
    tick(); tick();
    bus_b.sync = 1'b1; tick(); bus_b.sync = 1'b0;
    tick(); tick();
    check("ill_sel_err", 64'(bus_b.sel_err),    64'd1);
    check("ill_active",  64'(bus_b.active_des), 64'd12);
    check("ill_running", 64'(bus_b.running),    64'd0);
    check("ill_des_en",  64'(bus_b.des_en),     64'd0);
    repeat (6) tick();
    check("ill_stay_idle", 64'(bus_b.running), 64'd0);
    bus_b.des_sel = 6'd3;
    tick(); tick();
    bus_b.sync = 1'b1; tick(); bus_b.sync = 1'b0;
    tick(); tick();
    check("leg_sel_err", 64'(bus_b.sel_err), 64'd0);
    check("leg_switch",  64'(bus_b.running), 64'd0);
    repeat (4) tick();
    check("leg_running",   64'(bus_b.running),   64'd1);
    check("leg_des_en",    64'(bus_b.des_en),    64'h08);
    check("leg_des_reset", 64'(bus_b.des_reset), 64'hF7);

    // Basic select of design 5: running rises on the 7th edge after the pad.
    bus_a.des_sel = 6'd5;
    tick(); tick();
    bus_a.sync = 1'b1; tick(); bus_a.sync = 1'b0;
    repeat (5) tick();
    check("sel5_not_yet", 64'(bus_a.running), 64'd0);
    tick();
    check("sel5_running",   64'(bus_a.running),    64'd1);
    check("sel5_des_en",    bus_a.des_en,          64'h20);
    check("sel5_des_reset", bus_a.des_reset,       ~64'h20);
    check("sel5_active",    64'(bus_a.active_des), 64'd5);
    bus_a.des_io_out[5*IO_W +: IO_W] = 12'hA5C;
    tick();
    check("sel5_io_out", 64'(bus_a.io_out), 64'hA5C);
    bus_a.des_io_out[3*IO_W +: IO_W] = 12'h123;
    tick();
    check("slot3_ignored", 64'(bus_a.io_out), 64'hA5C);

    // User reset reaches the active design two edges after the pad.
    bus_a.user_reset = 1'b1;
    tick();
    check("ureset_lag", 64'(bus_a.des_reset[5]), 64'd0);
    tick();
    check("ureset_on",  64'(bus_a.des_reset[5]), 64'd1);
    check("ureset_en",  bus_a.des_en,             64'h20);
    bus_a.user_reset = 1'b0;
    tick(); tick();
    check("ureset_off", 64'(bus_a.des_reset[5]), 64'd0);

    // io_in reaches des_io_in on the 3rd edge.
    bus_a.io_in = 12'h3C7;
    tick(); tick();
    check("io_in_lag", 64'(bus_a.des_io_in), 64'd0);
    tick();
    check("io_in_arr", 64'(bus_a.des_io_in), 64'h3C7);

    // Switch to design 9 while running: exactly 4 cycles with nothing enabled.
    bus_a.des_io_out[9*IO_W +: IO_W] = 12'h9F1;
    bus_a.des_sel = 6'd9;
    tick(); tick();
    bus_a.sync = 1'b1; tick(); bus_a.sync = 1'b0;
    tick();
    check("sw_still_run", 64'(bus_a.running), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("sw_running", 64'(bus_a.running), 64'd0);
      check("sw_des_en",  bus_a.des_en,       64'd0);
      check("sw_io_out",  64'(bus_a.io_out),  64'd0);
    end
    tick();
    check("sw9_running", 64'(bus_a.running), 64'd1);
    check("sw9_des_en",  bus_a.des_en,       64'h200);
    check("sw9_active",  64'(bus_a.active_des), 64'd9);
    tick();
    check("sw9_io_out",  64'(bus_a.io_out),  64'h9F1);

    // Hold freezes IO and drops sync edges.
    bus_a.hold = 1'b1;
    tick(); tick();
    bus_a.io_in = 12'h555;
    bus_a.des_io_out[9*IO_W +: IO_W] = 12'h0AA;
    repeat (3) tick();
    check("hold_io_out",    64'(bus_a.io_out),    64'h9F1);
    check("hold_des_io_in", 64'(bus_a.des_io_in), 64'h3C7);
    bus_a.des_sel = 6'd2;
    tick(); tick();
    bus_a.sync = 1'b1; tick(); bus_a.sync = 1'b0;
    repeat (7) tick();
    check("hold_active",  64'(bus_a.active_des), 64'd9);
    check("hold_running", 64'(bus_a.running),    64'd1);
    check("hold_des_en",  bus_a.des_en,          64'h200);
    bus_a.hold = 1'b0;
    tick(); tick();
    check("unhold_lag", 64'(bus_a.io_out), 64'h9F1);
    tick();
    check("unhold_io_out",    64'(bus_a.io_out),    64'h0AA);
    check("unhold_des_io_in", 64'(bus_a.des_io_in), 64'h555);
    check("unhold_active",    64'(bus_a.active_des), 64'd9);

    // Asynchronous reset during the second SWITCH cycle.
    bus_a.des_sel = 6'd7;
    tick(); tick();
    bus_a.sync = 1'b1; tick(); bus_a.sync = 1'b0;
    tick(); tick(); tick();
    check("ar_in_switch", 64'(bus_a.active_des), 64'd7);
    #2 reset_n = 1'b0;
    #1;
    check("ar_active",    64'(bus_a.active_des), 64'd0);
    check("ar_des_io_in", 64'(bus_a.des_io_in),  64'd0);
    check("ar_des_reset", bus_a.des_reset,       ONES);
    check("ar_des_en",    bus_a.des_en,          64'd0);
    check("ar_io_out",    64'(bus_a.io_out),     64'd0);
    check("ar_running",   64'(bus_a.running),    64'd0);
    check("ar_sel_err",   64'(bus_a.sel_err),    64'd0);
    check("ar_b_des_en",  64'(bus_b.des_en),     64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (8) tick();
    check("ar_stay_idle", 64'(bus_a.running), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/design_select.md
# design_select

Chip-side design selector for the multi-project tapeout. It samples the harness-driven select pins (6-bit design number, sync, hold, user reset) and latches a new design number on each sync pulse. It sequences a reset window before enabling the selected design, then routes the 12-bit user IO to and from that design alone. It sits between the user-area pads and the per-design instances inside the user project wrapper.

## Interface

Parameters:
- NUM_DESIGNS, 64: number of design slots; legal design numbers are 0..NUM_DESIGNS-1, with NUM_DESIGNS ≤ 64.
- IO_W, 12: user IO width per design.
- SYNC_STAGES, 2: flop depth of the pad-input synchronizers, ≥ 2.
- RESET_HOLD, 4: number of cycles all designs are held in reset after a switch, ≥ 1.

Ports:
- clock  in  1  system clock (wishbone clock pad).
- reset_n  in  1  asynchronous, active-low reset of this block.
- des_sel  in  6  raw design-number pads (io_in[13:8]).
- sync  in  1  raw sync pad (io_in[6]); a rising edge commits des_sel.
- hold  in  1  raw hold pad (io_in[7]); freezes IO and blocks switching while high.
- user_reset  in  1  raw design-reset pad (io_in[5]), active-high.
- io_in  in  IO_W  raw user input pads (io_in[25:14]).
- io_out  out  IO_W  registered output of the selected design (to io_out[37:26]).
- des_io_in  out  IO_W  synchronized user inputs, broadcast to all designs.
- des_io_out  in  NUM_DESIGNS*IO_W  flattened design outputs; slot k occupies [k*IO_W +: IO_W].
- des_en  out  NUM_DESIGNS  one-hot enable of the running design; all zero when no design is running.
- des_reset  out  NUM_DESIGNS  per-design active-high reset.
- active_des  out  6  committed design number.
- running  out  1  high in state RUN.
- sel_err  out  1  sticky flag; the last committed number was ≥ NUM_DESIGNS.

## Operation

- Synchronizers: des_sel, sync, hold, user_reset, and io_in each pass through SYNC_STAGES flops (the _s signals). sync_rise = sync_s & ~sync_q, where sync_q is sync_s delayed one cycle.
- States:
  - IDLE: reset state; no design selected.
  - SWITCH: reset window, counter-driven.
  - RUN: selected design active.
- Any state, on sync_rise with hold_s=0:
  - Latch active_des ← des_sel_s.
  - If des_sel_s < NUM_DESIGNS: clear sel_err, go to SWITCH, load cnt ← RESET_HOLD-1.
  - Otherwise: set sel_err and go to IDLE.
- SWITCH: when cnt==0, go to RUN; otherwise cnt decrements. A sync_rise during SWITCH restarts the window with the new number.
- RUN: stays in RUN until a sync_rise is accepted.
- Outputs by state:
  - IDLE: des_en=0, des_reset=all ones, io_out=0, running=0.
  - SWITCH: des_en=0, des_reset=all ones, io_out=0, running=0.
  - RUN: des_en=1<<active_des. des_reset = ~des_en, except bit active_des = user_reset_s. running=1. io_out register ← des_io_out slot active_des every cycle.
- Hold: while hold_s=1, the io_out register and the des_io_in register keep their values, and sync_rise is ignored. The sync edge detector still tracks, so an edge that rises while hold is high is lost, not deferred. The state and the SWITCH counter continue to advance.
- reset_n low, asynchronous: state=IDLE, cnt=0, active_des=0, sel_err=0, io_out=0, des_io_in=0, des_en=0, des_reset=all ones, running=0, all synchronizer flops=0. Deassertion is synchronized by the top level.

## Timing

- Pad-to-_s latency is SYNC_STAGES cycles. A sync pad rise before edge 0 gives sync_rise in cycle SYNC_STAGES. The state becomes SWITCH at edge SYNC_STAGES+1.
- SWITCH lasts exactly RESET_HOLD cycles. running=1 at edge SYNC_STAGES+1+RESET_HOLD; with defaults, 7 cycles after the pad edge.
- io_out lags des_io_out by 1 cycle in RUN.
- io_in reaches des_io_in SYNC_STAGES+1 cycles after the pad.
- user_reset reaches des_reset of the active design SYNC_STAGES cycles after the pad.
- des_sel must be stable from SYNC_STAGES cycles before the sync pad edge until SYNC_STAGES cycles after it.

## Test plan

- Reset/idle: hold reset_n low, then release → all outputs at their reset values. des_reset=all ones, io_out=0, and they stay there with no sync activity for 20 cycles.
- Basic select: des_sel=5, pulse sync → running rises exactly 7 cycles after the pad edge. des_en=0x20, des_reset[5]=0, all other des_reset bits=1. Drive slot 5 output 0xA5C → io_out=0xA5C one cycle later. Slot 3 output changes must not affect io_out.
- Switch mid-run: while running design 5, set des_sel=9 and pulse sync → running drops for exactly 4 cycles with des_en=0 and io_out=0, then des_en=1<<9.
- Hold: in RUN, assert hold and toggle io_in and slot output → io_out and des_io_in are frozen. A sync pulse under hold leaves active_des unchanged. Releasing hold resumes updates.
- Illegal number: with NUM_DESIGNS=8, des_sel=12 plus sync → sel_err=1, state IDLE, des_en=0. A later legal select clears sel_err.
- Async reset mid-SWITCH: assert reset_n low at the second SWITCH cycle → all outputs take their reset values immediately, without waiting for a clock edge.
